// File: rtl/hyperbus_pkg.sv
// Shared hyperbus types: config, transfer descriptor, CA word.
// Also holds the CA builder and address mask helpers.
package hyperbus_pkg;

  localparam int HyperCaWidth    = 48;
  localparam int HyperBurstWidth = 16;
  localparam int HyperAddrWidth  = 32;

  typedef struct packed {
    logic [4:0] address_mask_msb;
    logic       phys_in_use;
    logic [7:0] t_burst_max;
  } hyper_cfg_t;

  typedef struct packed {
    logic                       write;
    logic                       address_space;
    logic                       burst_type;
    logic [HyperBurstWidth-1:0] burst;
    logic [HyperAddrWidth-1:0]  address;
  } hyper_tf_t;

  typedef struct packed {
    logic        rw_n;
    logic        address_space;
    logic        burst_type;
    logic [28:0] addr_hi;
    logic [12:0] rsvd;
    logic [2:0]  addr_lo;
  } hyper_ca_t;

  typedef enum logic {
    Idle,
    Send
  } hyper_ca_state_t;

  function automatic hyper_ca_t hyper_build_ca(
    input hyper_tf_t   tf,
    input logic [31:0] word_addr
  );
    hyper_ca_t ca;
    ca.rw_n          = ~tf.write;
    ca.address_space = tf.address_space;
    ca.burst_type    = tf.burst_type;
    ca.addr_hi       = word_addr[31:3];
    ca.rsvd          = '0;
    ca.addr_lo       = word_addr[2:0];
    return ca;
  endfunction

  function automatic logic [31:0] hyper_addr_mask(
    input logic [4:0] msb
  );
    return 32'hFFFF_FFFF >> (5'd31 - msb);
  endfunction

endpackage

// File: rtl/hyperbus_burst_splitter.sv
// Splits a linear burst into chunks of at most t_burst_max words.
// Registers the current chunk; load/next pulses advance it.
module hyperbus_burst_splitter
  import hyperbus_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_load,
  input  logic                       i_next,
  input  logic [HyperBurstWidth-1:0] i_burst,
  input  logic [31:0]                i_addr,
  input  logic                       i_linear,
  input  logic                       i_dual,
  input  hyper_cfg_t                 i_cfg,
  output logic [HyperBurstWidth-1:0] o_len,
  output logic                       o_last,
  output logic [31:0]                o_word_addr
);

  logic [HyperBurstWidth-1:0] r_rem;
  logic [HyperBurstWidth-1:0] r_max;
  logic [HyperBurstWidth-1:0] r_len;
  logic [31:0]                r_addr;
  logic [31:0]                r_mask;
  logic [31:0]                r_waddr;
  logic                       r_dual;
  logic                       r_split;
  logic                       r_last;

  logic [HyperBurstWidth-1:0] w_rem;
  logic [HyperBurstWidth-1:0] w_max;
  logic [HyperBurstWidth-1:0] w_len;
  logic [31:0]                w_mask;
  logic [31:0]                w_base;
  logic [31:0]                w_step;
  logic [31:0]                w_nxt;
  logic                       w_dual;
  logic                       w_split;

  // On load the first chunk is derived straight from the inputs
  always_comb begin
    w_mask = r_mask;
    w_dual = r_dual;
    w_split = r_split;
    w_max = r_max;
    w_rem = r_rem;
    w_base = r_addr;
    if (i_load) begin
      w_mask = hyper_addr_mask(i_cfg.address_mask_msb);
      w_dual = i_dual;
      w_split = i_linear && (i_cfg.t_burst_max != '0);
      w_max = HyperBurstWidth'(i_cfg.t_burst_max);
      w_rem = (i_burst == '0) ? HyperBurstWidth'(1) : i_burst;
      w_base = i_addr & w_mask;
    end
    w_len = (w_split && (w_rem > w_max)) ? w_max : w_rem;
    w_step = 32'(w_len) << (w_dual ? 2 : 1);
    w_nxt = (w_base + w_step) & w_mask;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem <= '0;
      r_max <= '0;
      r_len <= '0;
      r_addr <= '0;
      r_mask <= '0;
      r_waddr <= '0;
      r_dual <= 1'b0;
      r_split <= 1'b0;
      r_last <= 1'b0;
    end else if (i_load || i_next) begin
      r_mask <= w_mask;
      r_dual <= w_dual;
      r_split <= w_split;
      r_max <= w_max;
      r_len <= w_len;
      r_last <= (w_len == w_rem);
      r_rem <= w_rem - w_len;
      r_addr <= w_nxt;
      r_waddr <= w_dual ? (w_base >> 2) : (w_base >> 1);
    end
  end

  assign o_len = r_len;
  assign o_last = r_last;
  assign o_word_addr = r_waddr;

endmodule

// File: rtl/hyperbus_ca_gen.sv
// HyperBus command-address generator: chunking FSM and CA beat mux.
// Beats go out MSB first, replicated across PHYs.
module hyperbus_ca_gen
  import hyperbus_pkg::*;
#(
  parameter  int NumPhys      = 1,
  parameter  int PhyDataWidth = 8,
  localparam int CaBeatWidth  = 2 * PhyDataWidth,
  localparam int NumCaBeats   =
    (HyperCaWidth + CaBeatWidth - 1) / CaBeatWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  hyper_cfg_t                     cfg_i,
  input  hyper_tf_t                      tf_i,
  input  logic                           tf_valid_i,
  output logic                           tf_ready_o,
  output logic [NumPhys*CaBeatWidth-1:0] ca_o,
  output logic                           ca_valid_o,
  input  logic                           ca_ready_i,
  output logic                           ca_last_o,
  output logic [HyperBurstWidth-1:0]     chunk_burst_o,
  output logic                           chunk_write_o,
  output logic                           chunk_last_o
);

  localparam int PadWidth = NumCaBeats * CaBeatWidth;
  localparam int BeatIdxW = $clog2(NumCaBeats);

  hyper_ca_state_t     r_state;
  logic                r_tf_ready;
  logic                r_ca_valid;
  logic [BeatIdxW-1:0] r_beat;
  logic                r_write;
  logic                r_space;
  logic                r_btype;

  logic                w_load;
  logic                w_fire;
  logic                w_beat_last;
  logic                w_next;
  logic                w_dual;
  logic                w_chunk_last;
  logic [31:0]         w_waddr;
  hyper_tf_t           w_ca_tf;
  hyper_ca_t           w_ca;
  logic [PadWidth-1:0] w_pad;
  logic [NumCaBeats-1:0][CaBeatWidth-1:0] w_beats;
  logic [CaBeatWidth-1:0] w_beat;

  assign w_load = tf_valid_i && r_tf_ready;
  assign w_fire = r_ca_valid && ca_ready_i;
  assign w_beat_last = (r_beat == BeatIdxW'(NumCaBeats - 1));
  assign w_next = w_fire && w_beat_last && !w_chunk_last;
  assign w_dual = (NumPhys == 2) && cfg_i.phys_in_use;

  hyperbus_burst_splitter u_split (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_load      (w_load),
    .i_next      (w_next),
    .i_burst     (tf_i.burst),
    .i_addr      (tf_i.address),
    .i_linear    (tf_i.burst_type),
    .i_dual      (w_dual),
    .i_cfg       (cfg_i),
    .o_len       (chunk_burst_o),
    .o_last      (w_chunk_last),
    .o_word_addr (w_waddr)
  );

  always_comb begin
    w_ca_tf = '0;
    w_ca_tf.write = r_write;
    w_ca_tf.address_space = r_space;
    w_ca_tf.burst_type = r_btype;
    w_ca = hyper_build_ca(w_ca_tf, w_waddr);
  end

  // Left-align the CA so a short final beat is padded in its LSBs
  assign w_pad = PadWidth'(w_ca) << (PadWidth - HyperCaWidth);
  assign w_beats = w_pad;
  assign w_beat = w_beats[BeatIdxW'(NumCaBeats - 1) - r_beat];
  assign ca_o = {NumPhys{w_beat}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= Idle;
      r_tf_ready <= 1'b1;
      r_ca_valid <= 1'b0;
      r_beat <= '0;
      r_write <= 1'b0;
      r_space <= 1'b0;
      r_btype <= 1'b0;
    end else begin
      unique case (r_state)
        Idle: begin
          if (w_load) begin
            r_state <= Send;
            r_tf_ready <= 1'b0;
            r_ca_valid <= 1'b1;
            r_beat <= '0;
            r_write <= tf_i.write;
            r_space <= tf_i.address_space;
            r_btype <= tf_i.burst_type;
          end
        end
        Send: begin
          if (w_fire) begin
            if (w_beat_last) begin
              r_beat <= '0;
              if (w_chunk_last) begin
                r_state <= Idle;
                r_tf_ready <= 1'b1;
                r_ca_valid <= 1'b0;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= Idle;
      endcase
    end
  end

  assign tf_ready_o = r_tf_ready;
  assign ca_valid_o = r_ca_valid;
  assign ca_last_o = r_ca_valid && w_beat_last;
  assign chunk_write_o = r_write;
  assign chunk_last_o = w_chunk_last;

endmodule

// File: tb/tb_hyperbus_ca_gen.sv
// Bench for hyperbus_ca_gen: three configurations (8b x1, 16b x1, 8b x2),
// directed table, reset/stall sequence and randomized transfers.
module tb_hyperbus_ca_gen;
  import hyperbus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hyper_cfg_t cfg_i = '0;
  hyper_tf_t  tf_i = '0;
  logic       tfv[3];
  logic       ca_ready = 1'b0;

  logic [15:0] ca0;
  logic [31:0] ca1;
  logic [31:0] ca2;
  logic        rdy[3], v[3], l[3], w[3], cl[3];
  logic [15:0] b[3];

  hyperbus_ca_gen #(.NumPhys(1), .PhyDataWidth(8)) u0 (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg_i), .tf_i(tf_i),
    .tf_valid_i(tfv[0]), .tf_ready_o(rdy[0]), .ca_o(ca0),
    .ca_valid_o(v[0]), .ca_ready_i(ca_ready), .ca_last_o(l[0]),
    .chunk_burst_o(b[0]), .chunk_write_o(w[0]), .chunk_last_o(cl[0]));

  hyperbus_ca_gen #(.NumPhys(1), .PhyDataWidth(16)) u1 (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg_i), .tf_i(tf_i),
    .tf_valid_i(tfv[1]), .tf_ready_o(rdy[1]), .ca_o(ca1),
    .ca_valid_o(v[1]), .ca_ready_i(ca_ready), .ca_last_o(l[1]),
    .chunk_burst_o(b[1]), .chunk_write_o(w[1]), .chunk_last_o(cl[1]));

  hyperbus_ca_gen #(.NumPhys(2), .PhyDataWidth(8)) u2 (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg_i), .tf_i(tf_i),
    .tf_valid_i(tfv[2]), .tf_ready_o(rdy[2]), .ca_o(ca2),
    .ca_valid_o(v[2]), .ca_ready_i(ca_ready), .ca_last_o(l[2]),
    .chunk_burst_o(b[2]), .chunk_write_o(w[2]), .chunk_last_o(cl[2]));

  int cur = 0;
  logic [63:0] g_ca;
  always_comb begin
    case (cur)
      1: g_ca = {32'b0, ca1};
      2: g_ca = {32'b0, ca2};
      default: g_ca = {48'b0, ca0};
    endcase
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d): got 0x%0h, want 0x%0h",
               name, cur, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] beat;
    bit          last;
    int          len;
    bit          clast;
    bit          wr;
  } beat_t;
  beat_t q[$];

  function automatic int bw_of(int sel);
    return (sel == 1) ? 32 : 16;
  endfunction

  // Reference: walk the burst in chunks, build each 48-bit CA arithmetically
  task automatic build_exp(input int sel, input hyper_tf_t tf,
                           input hyper_cfg_t cfg);
    int bw = bw_of(sel);
    int nb = (48 + bw - 1) / bw;
    bit dual = (sel == 2) && cfg.phys_in_use;
    longint unsigned mask = (64'd1 << (cfg.address_mask_msb + 1)) - 1;
    longint unsigned addr = tf.address & mask;
    int rem = (tf.burst == 0) ? 1 : int'(tf.burst);
    int tmax = int'(cfg.t_burst_max);
    bit split = (tmax != 0) && tf.burst_type;
    q.delete();
    while (rem > 0) begin
      int len = (split && rem > tmax) ? tmax : rem;
      logic [63:0] wa = dual ? addr / 4 : addr / 2;
      logic [63:0] caw;
      logic [63:0] pad;
      caw = (64'(!tf.write) << 47) | (64'(tf.address_space) << 46) |
            (64'(tf.burst_type) << 45) | ((wa >> 3) << 16) | (wa & 7);
      pad = caw << (nb * bw - 48);
      for (int k = 0; k < nb; k++) begin
        beat_t e;
        logic [63:0] bt;
        bt = (pad >> ((nb - 1 - k) * bw)) & ((64'd1 << bw) - 1);
        if (sel == 2) bt = bt | (bt << 16);
        e.beat = bt;
        e.last = (k == nb - 1);
        e.len = len;
        e.clast = (rem == len);
        e.wr = tf.write;
        q.push_back(e);
      end
      rem -= len;
      addr = ((addr + longint'(len) * (dual ? 4 : 2)) % (64'd1 << 32)) & mask;
    end
  endtask

  task automatic hs(input hyper_tf_t tf, input hyper_cfg_t cfg);
    @(posedge clk); #1;
    tf_i = tf; cfg_i = cfg; tfv[cur] = 1'b1; ca_ready = 1'b0;
    @(negedge clk);
    chk("tf_ready_idle", 64'(rdy[cur]), 1);
    chk("valid_idle", 64'(v[cur]), 0);
  endtask

  task automatic step(input bit r, input bit spam);
    @(posedge clk); #1;
    tfv[cur] = spam; ca_ready = r;
    @(negedge clk);
    chk("ca_valid", 64'(v[cur]), 1);
    chk("tf_ready_busy", 64'(rdy[cur]), 0);
    chk("ca_beat", g_ca, q[0].beat);
    chk("ca_last", 64'(l[cur]), 64'(q[0].last));
    chk("chunk_burst", 64'(b[cur]), 64'(q[0].len));
    chk("chunk_last", 64'(cl[cur]), 64'(q[0].clast));
    chk("chunk_write", 64'(w[cur]), 64'(q[0].wr));
    if (r) void'(q.pop_front());
  endtask

  task automatic run_tf(input int sel, input hyper_tf_t tf,
                        input hyper_cfg_t cfg, input int stall_pct,
                        input bit spam, output logic [63:0] ca_first,
                        output int nchunks, output int len0);
    int bw = bw_of(sel);
    int nb = (48 + bw - 1) / bw;
    int cyc = 0;
    logic [63:0] acc = '0;
    cur = sel;
    build_exp(sel, tf, cfg);
    nchunks = 0;
    len0 = -1;
    hs(tf, cfg);
    while (q.size() > 0 && cyc < 3000) begin
      bit r = ($urandom_range(99) >= stall_pct);
      step(r, spam);
      if (len0 < 0) len0 = int'(b[cur]);
      if (r) begin
        if (nchunks == 0)
          acc = (acc << bw) | (g_ca & ((64'd1 << bw) - 1));
        if (l[cur]) nchunks++;
      end
      cyc++;
    end
    if (q.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout (inst %0d): %0d beats left", sel, q.size());
    end
    @(posedge clk); #1;
    tfv[sel] = 1'b0; ca_ready = 1'b0;
    @(negedge clk);
    chk("done_tf_ready", 64'(rdy[sel]), 1);
    chk("done_valid", 64'(v[sel]), 0);
    @(negedge clk);
    chk("spam_ignored", 64'(v[sel]), 0);
    ca_first = acc >> (nb * bw - 48);
  endtask

  function automatic hyper_tf_t mk_tf(logic wr, logic sp, logic bt,
                                      logic [31:0] a, logic [15:0] n);
    hyper_tf_t t;
    t.write = wr; t.address_space = sp; t.burst_type = bt;
    t.address = a; t.burst = n;
    return t;
  endfunction

  function automatic hyper_cfg_t mk_cfg(logic [4:0] msb, logic piu,
                                        logic [7:0] tmax);
    hyper_cfg_t c;
    c.address_mask_msb = msb; c.phys_in_use = piu; c.t_burst_max = tmax;
    return c;
  endfunction

  typedef struct {
    int          sel;
    logic        wr, sp, bt;
    logic [31:0] addr;
    logic [15:0] burst;
    logic [7:0]  tmax;
    logic [4:0]  msb;
    logic        piu;
    logic [63:0] exp_ca;
    int          exp_chunks;
    int          exp_len;
  } vec_t;
  vec_t vt[8];

  initial begin
    logic [63:0] caf;
    int nch, ln0;
    hyper_tf_t t;
    vt[0] = '{0, 0, 0, 1, 32'h1000, 16'd8, 8'd0, 5'd31, 0,
              64'hA000_0100_0000, 1, 8};
    vt[1] = '{0, 0, 0, 1, 32'h1000, 16'd40, 8'd16, 5'd31, 0,
              64'hA000_0100_0000, 3, 16};
    vt[2] = '{1, 1, 0, 1, 32'h000E, 16'd4, 8'd0, 5'd31, 0,
              64'h2000_0000_0007, 1, 4};
    vt[3] = '{2, 0, 0, 1, 32'h0040, 16'd2, 8'd0, 5'd31, 1,
              64'hA000_0002_0000, 1, 2};
    vt[4] = '{0, 0, 0, 0, 32'h1FFE, 16'd40, 8'd16, 5'd11, 0,
              64'h8000_00FF_0007, 1, 40};
    vt[5] = '{0, 0, 0, 1, 32'h0000, 16'd0, 8'd4, 5'd31, 0,
              64'hA000_0000_0000, 1, 1};
    vt[6] = '{2, 0, 1, 1, 32'h0040, 16'd2, 8'd0, 5'd31, 0,
              64'hE000_0004_0000, 1, 2};
    vt[7] = '{0, 0, 0, 1, 32'h0FF8, 16'd12, 8'd4, 5'd11, 0,
              64'hA000_00FF_0004, 3, 4};
    for (int i = 0; i < 3; i++) tfv[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cur = s;
      #1;
      chk("rst_tf_ready", 64'(rdy[s]), 1);
      chk("rst_valid", 64'(v[s]), 0);
      chk("rst_ca_last", 64'(l[s]), 0);
      chk("rst_chunk_burst", 64'(b[s]), 0);
      chk("rst_chunk_last", 64'(cl[s]), 0);
      chk("rst_chunk_write", 64'(w[s]), 0);
    end

    for (int i = 0; i < 8; i++) begin
      run_tf(vt[i].sel,
             mk_tf(vt[i].wr, vt[i].sp, vt[i].bt, vt[i].addr, vt[i].burst),
             mk_cfg(vt[i].msb, vt[i].piu, vt[i].tmax),
             0, i[0], caf, nch, ln0);
      chk($sformatf("vec%0d_ca", i), caf, vt[i].exp_ca);
      chk($sformatf("vec%0d_chunks", i), 64'(nch), 64'(vt[i].exp_chunks));
      chk($sformatf("vec%0d_len0", i), 64'(ln0), 64'(vt[i].exp_len));
    end

    // Stall mid-CA, then reset during the second chunk
    cur = 0;
    t = mk_tf(0, 0, 1, 32'h1000, 16'd40);
    build_exp(0, t, mk_cfg(5'd31, 0, 8'd16));
    hs(t, mk_cfg(5'd31, 0, 8'd16));
    step(1, 0);
    repeat (5) step(0, 0);
    repeat (3) step(1, 0);
    chk("chunk2_burst", 64'(b[0]), 16);
    @(posedge clk); #1;
    rst = 1'b1; ca_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(v[0]), 0);
    chk("midrst_tf_ready", 64'(rdy[0]), 1);
    chk("midrst_chunk_burst", 64'(b[0]), 0);
    chk("midrst_chunk_last", 64'(cl[0]), 0);
    repeat (2) @(negedge clk);
    chk("midrst_stays_idle", 64'(v[0]), 0);
    q.delete();
    run_tf(0, mk_tf(1, 1, 1, 32'h0000_2000, 16'd3), mk_cfg(5'd31, 0, 8'd0),
           20, 0, caf, nch, ln0);
    chk("postrst_ca", caf, 64'h6000_0200_0000);
    chk("postrst_chunks", 64'(nch), 1);

    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(2);
      logic [4:0] msb = 5'($urandom_range(31, 4));
      t = mk_tf(1'($urandom), 1'($urandom), 1'($urandom_range(3) != 0),
                $urandom, 16'($urandom_range(50)));
      run_tf(sel, t,
             mk_cfg(msb, 1'($urandom), 8'($urandom_range(20))),
             $urandom_range(50), 1'($urandom), caf, nch, ln0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperbus_ca_gen.md
Name: hyperbus_ca_gen

Overview:
Parametrised command-address generator between the hyperbus transfer queue and the PHY(s).
- Accepts one transfer descriptor (`hyper_tf_t`) at a time.
- Splits linear bursts into chunks no longer than `cfg.t_burst_max`.
- For each chunk, builds the 48-bit CA word and serialises it onto a DDR beat bus sized for 8- or 16-bit PHYs, with one or two PHYs.
- Chunk length and write flag accompany each CA stream for the downstream data path.

Parameters:
- NumPhys, 1, number of PHYs driven; legal 1 or 2.
- PhyDataWidth, 8, DQ width per PHY; legal 8 or 16.
- CaBeatWidth, 2*PhyDataWidth, bits per PHY per clock (DDR); derived, not overridable.
- NumCaBeats, ceil(48/CaBeatWidth), CA beats per chunk: 3 for width 8, 2 for width 16; derived.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_i  in  hyper_cfg_t  configuration; sampled at tf handshake, held for the whole transfer.
- tf_i  in  hyper_tf_t  transfer descriptor; address is a byte address, burst is in 16-bit words.
- tf_valid_i  in  1  descriptor valid.
- tf_ready_o  out  1  descriptor accepted.
- ca_o  out  NumPhys*CaBeatWidth  CA beat, replicated per PHY; PHY0 in the LSBs.
- ca_valid_o  out  1  CA beat valid.
- ca_ready_i  in  1  PHY consumes beat.
- ca_last_o  out  1  last beat of the current chunk's CA.
- chunk_burst_o  out  HyperBurstWidth  word count of the current chunk; stable while ca_valid_o=1.
- chunk_write_o  out  1  chunk is a write.
- chunk_last_o  out  1  current chunk is the final chunk of the transfer.

Behaviour:
- Reset: state=Idle, tf_ready_o=1, ca_valid_o=0, ca_last_o=0, chunk_* outputs=0. Reset mid-transfer discards remaining chunks; nothing resumes.
- FSM states: Idle, Send.
- Idle: tf_ready_o=1.
  - On tf_valid_i&tf_ready_o, register tf and cfg, compute the first chunk, go to Send.
  - Latency: first beat on ca_o one cycle after the handshake.
- Send: tf_ready_o=0, ca_valid_o=1.
  - Beat index advances on ca_valid_o&ca_ready_i.
  - Stalls (ca_ready_i=0) hold ca_o and all chunk_* outputs stable.
  - On the beat with ca_last_o: if remaining words = 0, go to Idle; otherwise compute the next chunk and stay in Send.
  - The next chunk's beat 0 appears in the following cycle; no bubble.
- Word size (16-bit words per address step):
  - Dual mode = (NumPhys==2 && cfg.phys_in_use); bytes per word = 4, else 2.
  - word_addr = masked_addr >> 2 if dual, else >> 1.
  - masked_addr = byte address with bits above cfg.address_mask_msb cleared.
- Chunking:
  - Unsplit transfer (single chunk, chunk_last_o=1) when cfg.t_burst_max==0, or burst_type==0 (wrapped).
  - Otherwise chunk_len = min(remaining, zero-extended t_burst_max).
  - Next byte address = previous + chunk_len*bytes_per_word, modulo 2^32, then re-masked. Wrap-around beyond the mask aliases to low addresses; no error is raised.
- burst==0 on input: treated as 1 word.
- CA format: CA[47]=~write, CA[46]=address_space, CA[45]=burst_type, CA[44:16]=word_addr[31:3] zero-extended, CA[15:3]=0, CA[2:0]=word_addr[2:0].
- Serialisation:
  - MSB first; beat k = CA[47-k*CaBeatWidth -: CaBeatWidth].
  - The final beat is zero-padded in its LSBs when 48 is not a multiple of CaBeatWidth.
- tf_valid_i while in Send is ignored (not accepted) until Idle.

Decomposition:
- hyperbus_pkg additions:
  - hyper_ca_t: 48-bit packed CA with the field order above.
  - hyper_ca_state_t: enum Idle/Send.
  - Function hyper_build_ca(tf, word_addr) -> hyper_ca_t.
  - Constant HyperCaWidth=48.
- Sub-module hyperbus_burst_splitter: holds the remaining count and next address, and emits chunk_len/chunk_last on a request pulse.
- Top level owns the FSM and the beat mux.

Test Plan:
- PhyDataWidth=8, NumPhys=1, read, addr 0x0000_1000, burst 8, linear, t_burst_max=0 -> one chunk, beats 0xA000, 0x0100, 0x0000, ca_last_o on beat 2, chunk_burst_o=8, chunk_last_o=1.
- Same read with burst 40, t_burst_max=16 -> chunks of 16, 16, 8 at byte addrs 0x1000, 0x1020, 0x1040 (CA[44:16]=0x100, 0x102, 0x104); chunk_last_o only on the third; no idle cycle between chunks.
- PhyDataWidth=16, write, addr 0x0000_000E, burst 4 -> 2 beats: 0x2000_0000, then 0x0007_0000 (CA[2:0]=7, low half zero-padded).
- NumPhys=2, phys_in_use=1, addr 0x40, burst 2, linear, read -> word_addr 0x10, CA 0xA000_0002_0000, ca_o carries identical halves per PHY.
- ca_ready_i low for 5 cycles mid-CA, then rst_i pulsed during the second chunk -> ca_o stable during the stall; after reset ca_valid_o=0, tf_ready_o=1; a new tf is accepted cleanly.
- Wrapped burst (burst_type=0), burst 40, t_burst_max=16 -> single chunk of 40; address_mask_msb=11 with addr 0x0000_1FFE -> CA[44:16] and CA[2:0] derived from 0x0FFE only.
